alu_issue_unit: RTL and testbench
=================================

# alu_issue_unit

Issue/writeback stage wrapped around the 8-bit ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads two operands from an internal 8×8-bit register file.
- Drives the ALU operand/function inputs, captures result, high product and flags, and writes them back to the register file and the architectural status register.
- A host write port preloads registers; a debug port reads them.

## Interface
Parameters:
- REG_COUNT, 8: number of registers; register address width is log2(REG_COUNT) = 3.
- DATA_W, 8: register and ALU width; fixed, must match the ALU.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  unit can accept; equals (state==IDLE) && !host_wr_en.
- in_instr  in  16  instruction: [15:12] op (ALU function code), [11:9] rd, [8:6] rs, [5:0] ignored.
- host_wr_en  in  1  host register write.
- host_wr_addr  in  3  host write address.
- host_wr_data  in  8  host write data.
- dbg_addr  in  3  debug read address.
- dbg_data  out  8  combinational read of register dbg_addr.
- alu_a, alu_b  out  8  registered ALU operands.
- alu_fsl  out  4  registered ALU function code.
- alu_result  in  8  ALU result (combinational from alu_a/alu_b/alu_fsl).
- alu_mul_high  in  8  ALU high product byte.
- alu_sreg  in  4  ALU flags {V,N,C,Z}.
- sreg  out  4  architectural status register.
- done  out  1  one-cycle pulse when an instruction retires.

## Operation
- Reset values: all registers 0x00, sreg 0x0, state IDLE, alu_a/alu_b 0x00, alu_fsl 0x0, done 0.
- IDLE:
  - in_valid && in_ready: latch op/rd/rs.
  - alu_a <= R[rd], alu_b <= R[rs], alu_fsl <= op.
  - Go to EXEC.
- EXEC (one cycle; ALU inputs stable), at the end of the cycle:
  - sreg <= alu_sreg.
  - op != 4'b1111: R[rd] <= alu_result.
  - op == 4'b1111 (compare): R[rd] <= alu_result; compare writes the ALU's 0/1 result.
  - op == 4'b1110 (multiply): latch alu_mul_high into hi_q and go to WB_HI.
  - All other ops: pulse done and go to IDLE.
- WB_HI:
  - R[(rd+1) mod 8] <= hi_q, pulse done, go to IDLE.
  - rd=7 wraps to R0.
- Host write:
  - R[host_wr_addr] <= host_wr_data in any cycle while state==IDLE.
  - Ignored in EXEC/WB_HI; the host must hold host_wr_en until in_ready would otherwise be high.
  - host_wr_en forces in_ready low, so a host write and an instruction accept never coincide.
- Operand hazard: rd==rs is legal; both operands read the same pre-instruction value.
- sreg keeps its value between instructions.
  - ADDC/SUBC carry-in comes from the ALU's own flag path.
  - sreg is the externally visible copy only.
- Reset asserted in EXEC or WB_HI: abort immediately, no writeback, all state returns to reset values.

## Timing
- Accept at edge k.
- EXEC during cycle k+1; writeback and sreg update at edge k+2.
- done high in cycle k+2 for non-multiply ops.
- Multiply: low byte written at k+2, high byte at k+3, done high in cycle k+3.
- in_ready high again in cycle k+2 (k+3 for multiply).
  - Throughput: one instruction per 2 cycles, 3 for multiply.
- dbg_data reflects writes from the following cycle (register-file read after the edge).

## Structure
- Shared package alu_pkg:
  - op code constants (ADD=0 … MULTIPLY=14, COMPARE=15).
  - SREG bit indices (Z=0, C=1, N=2, V=3).
  - state enum {IDLE, EXEC, WB_HI}.
  - instruction field positions.
- Sub-module regfile8x8: asynchronous reset, one synchronous write port, three asynchronous read ports (rd, rs, dbg).
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset: after rst_n low, dbg_data=0x00 for all addresses, sreg=0, in_ready=1, done=0.
- ADD: host R1=0x7F, R2=0x01; issue op=0000 rd=1 rs=2.
  - R1=0x80 at k+2, done pulse in cycle k+2.
  - sreg shows N=1, V=1.
- MULTIPLY wrap: R7=0x10, R3=0x20; issue op=1110 rd=7 rs=3.
  - R7=0x00 at k+2, R0=0x02 at k+3.
  - done in k+3 only; in_ready low in k+2.
- Handshake: hold in_valid with two back-to-back instructions; second accepted exactly 2 cycles after the first. host_wr_en high in IDLE with in_valid high: in_ready=0, host data written, no instruction accepted.
- Reset mid-op: assert rst_n=0 during EXEC of ADD to R4. R4 stays 0x00, no done, state IDLE after release.
- COMPARE: R5=0x09, R6=0x03; issue op=1111 rd=5 rs=6. R5 and sreg take the ALU's result and flags at k+2.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU issue/writeback slice.
//   - ALU function codes carried in the instruction op field
//   - status register bit positions {V,N,C,Z}
//   - issue FSM state encoding
//   - instruction field positions
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_REG_AW = 3;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ROL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_INC  = 4'd12;
    localparam logic [3:0] OP_DEC  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_CMP  = 4'd15;

    localparam int SREG_Z = 0;
    localparam int SREG_C = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;

    localparam int INSTR_OP_MSB = 15;
    localparam int INSTR_OP_LSB = 12;
    localparam int INSTR_RD_MSB = 11;
    localparam int INSTR_RD_LSB = 9;
    localparam int INSTR_RS_MSB = 8;
    localparam int INSTR_RS_LSB = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        WB_HI = 2'd2
    } state_t;

endpackage

// File: rtl/regfile8x8.sv
// regfile8x8: small register file for the issue unit.
//   clk, rst_n           clock and asynchronous active-low reset (clears all entries)
//   i_we/i_waddr/i_wdata single synchronous write port
//   i_raddr_a/o_rdata_a  asynchronous read port for the destination operand
//   i_raddr_b/o_rdata_b  asynchronous read port for the source operand
//   i_raddr_d/o_rdata_d  asynchronous read port for the debug interface
module regfile8x8 #(
    parameter  int REG_COUNT = 8,
    parameter  int DATA_W    = 8,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [AW-1:0]     i_raddr_d,
    output logic [DATA_W-1:0] o_rdata_d
);

    logic [DATA_W-1:0] r_mem [REG_COUNT];

    // Storage array: everything clears on reset, one write per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];
    assign o_rdata_d = r_mem[i_raddr_d];

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/writeback stage wrapped around an external 8-bit ALU.
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_in_valid/o_in_ready      instruction handshake; i_in_instr = {op, rd, rs, 6'bx}
//   i_host_wr_*                host preload port, honoured only while idle
//   i_dbg_addr/o_dbg_data      combinational register read for debug
//   o_alu_a/o_alu_b/o_alu_fsl  registered operands and function code to the ALU
//   i_alu_result/_mul_high/_sreg  ALU outputs captured at the end of EXEC
//   o_sreg                     architectural copy of the ALU flags {V,N,C,Z}
//   o_done                     one-cycle pulse when an instruction retires
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int REG_COUNT = 8,
    parameter int DATA_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [15:0]                  i_in_instr,
    input  logic                         i_host_wr_en,
    input  logic [$clog2(REG_COUNT)-1:0] i_host_wr_addr,
    input  logic [DATA_W-1:0]            i_host_wr_data,
    input  logic [$clog2(REG_COUNT)-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]            o_dbg_data,
    output logic [DATA_W-1:0]            o_alu_a,
    output logic [DATA_W-1:0]            o_alu_b,
    output logic [3:0]                   o_alu_fsl,
    input  logic [DATA_W-1:0]            i_alu_result,
    input  logic [DATA_W-1:0]            i_alu_mul_high,
    input  logic [3:0]                   i_alu_sreg,
    output logic [3:0]                   o_sreg,
    output logic                         o_done
);

    localparam int AW = $clog2(REG_COUNT);

    state_t            r_state;
    state_t            w_next_state;
    logic [AW-1:0]     r_rd;
    logic [DATA_W-1:0] r_hi;

    logic [3:0]        w_instr_op;
    logic [AW-1:0]     w_instr_rd;
    logic [AW-1:0]     w_instr_rs;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_rs_data;
    logic              w_wr_en;
    logic [AW-1:0]     w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_done;
    logic              w_unused_instr;

    assign w_instr_op     = i_in_instr[INSTR_OP_MSB:INSTR_OP_LSB];
    assign w_instr_rd     = i_in_instr[INSTR_RD_MSB:INSTR_RD_LSB];
    assign w_instr_rs     = i_in_instr[INSTR_RS_MSB:INSTR_RS_LSB];
    assign w_unused_instr = &{1'b0, i_in_instr[5:0]};

    // A pending host write blocks acceptance so the single write port never
    // has to arbitrate between the host and an instruction.
    assign o_in_ready = (r_state == IDLE) && !i_host_wr_en;
    assign w_accept   = i_in_valid && o_in_ready;

    // Operand reads are addressed straight from the offered instruction so
    // the values are captured on the accepting edge.
    regfile8x8 #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_wr_en),
        .i_waddr   (w_wr_addr),
        .i_wdata   (w_wr_data),
        .i_raddr_a (w_instr_rd),
        .o_rdata_a (w_rd_data),
        .i_raddr_b (w_instr_rs),
        .o_rdata_b (w_rs_data),
        .i_raddr_d (i_dbg_addr),
        .o_rdata_d (o_dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sequencing and register-file write selection. The host owns the write
    // port in IDLE; EXEC writes the low result (compare included); WB_HI
    // writes the high product into the next register, wrapping past the top.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_rd;
        w_wr_data    = i_alu_result;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_host_wr_en) begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = i_host_wr_addr;
                    w_wr_data = i_host_wr_data;
                end else if (i_in_valid) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_wr_en = 1'b1;
                if (o_alu_fsl == OP_MUL) begin
                    w_next_state = WB_HI;
                end else begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            WB_HI: begin
                w_wr_en      = 1'b1;
                w_wr_addr    = r_rd + AW'(1);
                w_wr_data    = r_hi;
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Datapath registers: ALU operands are loaded on accept and held through
    // EXEC; flags and the high product are captured as EXEC finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd      <= '0;
            r_hi      <= '0;
            o_alu_a   <= '0;
            o_alu_b   <= '0;
            o_alu_fsl <= '0;
            o_sreg    <= '0;
            o_done    <= 1'b0;
        end else begin
            o_done <= w_done;
            if (w_accept) begin
                r_rd      <= w_instr_rd;
                o_alu_a   <= w_rd_data;
                o_alu_b   <= w_rs_data;
                o_alu_fsl <= w_instr_op;
            end
            if (r_state == EXEC) begin
                o_sreg <= i_alu_sreg;
                if (o_alu_fsl == OP_MUL) begin
                    r_hi <= i_alu_mul_high;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: bench for alu_issue_unit with a stand-in ALU, an
// event-scheduled reference model and a per-cycle compare process.
`timescale 1ns/100ps
module tb_alu_issue_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inValid = 1'b0;
    logic       inReady;
    logic [15:0] inInstr = 16'h0000;
    logic       hostWrEn = 1'b0;
    logic [2:0] hostWrAddr = 3'd0;
    logic [7:0] hostWrData = 8'h00;
    logic [2:0] dbgAddr = 3'd0;
    logic [7:0] dbgData;
    logic [7:0] aluA, aluB;
    logic [3:0] aluFsl;
    logic [7:0] aluResult, aluMulHigh;
    logic [3:0] aluSreg;
    logic [3:0] sreg;
    logic       done;

    int totalChecks = 0;
    int badChecks = 0;
    int cycleCount = 0;
    bit checkOn = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    alu_issue_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_in_valid     (inValid),
        .o_in_ready     (inReady),
        .i_in_instr     (inInstr),
        .i_host_wr_en   (hostWrEn),
        .i_host_wr_addr (hostWrAddr),
        .i_host_wr_data (hostWrData),
        .i_dbg_addr     (dbgAddr),
        .o_dbg_data     (dbgData),
        .o_alu_a        (aluA),
        .o_alu_b        (aluB),
        .o_alu_fsl      (aluFsl),
        .i_alu_result   (aluResult),
        .i_alu_mul_high (aluMulHigh),
        .i_alu_sreg     (aluSreg),
        .o_sreg         (sreg),
        .o_done         (done)
    );

    // Stand-in ALU returning {flags V,N,C,Z, high byte, result}.
    function automatic logic [19:0] aluEval(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic [7:0]  hi;
        logic        c, v, z, n;
        s = 9'h000; p = 16'h0000; hi = 8'h00; c = 1'b0; v = 1'b0;
        case (f)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd2: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8];
                        v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd14: begin p = a * b; r = p[7:0]; hi = p[15:8]; end
            4'd15: begin s = {1'b0, a} - {1'b0, b}; r = (a > b) ? 8'd1 : 8'd0;
                         c = s[8]; v = (a[7] != b[7]) && (s[7] != a[7]); end
            default: r = a + 8'd3;
        endcase
        if (f == 4'd15) begin z = (s[7:0] == 8'h00); n = s[7]; end
        else begin z = (r == 8'h00); n = r[7]; end
        return {v, n, c, z, hi, r};
    endfunction

    logic [19:0] aluOut;
    assign aluOut     = aluEval(aluA, aluB, aluFsl);
    assign aluResult  = aluOut[7:0];
    assign aluMulHigh = aluOut[15:8];
    assign aluSreg    = aluOut[19:16];

    // Reference model: each accepted instruction schedules its effects at
    // fixed edges after acceptance (low result/flags one edge later, high
    // product two edges later for multiply); the unit is idle when nothing
    // is scheduled.
    logic [7:0] mdlRegs [8];
    logic [3:0] mdlSreg;
    bit         expDone;
    int         mdlEdge = 0;
    int         lowAt = -1;
    int         hiAt = -1;
    logic [2:0] pRd, pRs, hiIdx;
    logic [7:0] pLow, pHi;
    logic [3:0] pFlags, pOp;
    bit         pMul, idleBefore;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mdlRegs[i] = 8'h00;
            mdlSreg = 4'h0; expDone = 1'b0; lowAt = -1; hiAt = -1;
        end else begin
            mdlEdge++;
            idleBefore = (lowAt < 0) && (hiAt < 0);
            expDone = 1'b0;
            if (idleBefore && hostWrEn) mdlRegs[hostWrAddr] = hostWrData;
            if (lowAt == mdlEdge) begin
                mdlRegs[pRd] = pLow; mdlSreg = pFlags;
                if (!pMul) expDone = 1'b1;
                lowAt = -1;
            end
            if (hiAt == mdlEdge) begin
                hiIdx = pRd + 3'd1;
                mdlRegs[hiIdx] = pHi; expDone = 1'b1; hiAt = -1;
            end
            if (idleBefore && !hostWrEn && inValid) begin
                pOp = inInstr[15:12]; pRd = inInstr[11:9]; pRs = inInstr[8:6];
                {pFlags, pHi, pLow} = aluEval(mdlRegs[pRd], mdlRegs[pRs], pOp);
                pMul = (pOp == 4'd14);
                lowAt = mdlEdge + 1;
                hiAt = pMul ? mdlEdge + 2 : -1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("ready", 16'(inReady), 16'((lowAt < 0) && (hiAt < 0) && !hostWrEn));
            checkOutput("done", 16'(done), 16'(expDone));
            checkOutput("sreg", 16'(sreg), 16'(mdlSreg));
            checkOutput("dbgData", 16'(dbgData), 16'(mdlRegs[dbgAddr]));
        end
    end

    task automatic readReg(input logic [2:0] addr, output logic [7:0] data);
        dbgAddr = addr;
        #0.5;
        data = dbgData;
    endtask

    // Offer one instruction; returns the edge number it was accepted on.
    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd,
                                 input logic [2:0] rs, input bit keepValid,
                                 output int acceptEdge);
        bit accepted;
        accepted = 1'b0;
        acceptEdge = -100;
        inValid = 1'b1;
        inInstr = {op, rd, rs, 6'($urandom)};
        for (int w = 0; w < 20 && !accepted; w++) begin
            @(negedge clk);
            if (inReady) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        if (accepted) acceptEdge = cycleCount;
        else checkOutput("acceptTimeout", 16'd0, 16'd1);
        if (!keepValid) inValid = 1'b0;
    endtask

    task automatic waitIdle();
        for (int w = 0; w < 10 && !((lowAt < 0) && (hiAt < 0)); w++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hostWrite(input logic [2:0] addr, input logic [7:0] data);
        waitIdle();
        hostWrEn = 1'b1; hostWrAddr = addr; hostWrData = data;
        @(posedge clk);
        #1;
        hostWrEn = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            dbgAddr = 3'($urandom);
        end
    endtask

    int a1, a2;
    logic [7:0] rv;

    initial begin
        // Reset state
        #2;
        checkOn = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            readReg(3'(i), rv);
            checkOutput("resetReg", 16'(rv), 16'h00);
        end
        checkOutput("resetSreg", 16'(sreg), 16'h0);
        checkOutput("resetReady", 16'(inReady), 16'd1);
        checkOutput("resetDone", 16'(done), 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idleCycles(2);

        // ADD 0x7F + 0x01 into R1
        hostWrite(3'd1, 8'h7F);
        hostWrite(3'd2, 8'h01);
        applyStimulus(4'd0, 3'd1, 3'd2, 1'b0, a1);
        @(negedge clk);
        checkOutput("addExecDone", 16'(done), 16'd0);
        @(negedge clk);
        readReg(3'd1, rv);
        checkOutput("addR1", 16'(rv), 16'h80);
        checkOutput("addSreg", 16'(sreg), 16'hC);
        checkOutput("addDone", 16'(done), 16'd1);
        @(posedge clk); #1;

        // MULTIPLY with rd wrap: 0x10 * 0x20 = 0x0200
        hostWrite(3'd7, 8'h10);
        hostWrite(3'd3, 8'h20);
        applyStimulus(4'd14, 3'd7, 3'd3, 1'b0, a1);
        @(negedge clk);
        checkOutput("mulExecDone", 16'(done), 16'd0);
        @(negedge clk);
        readReg(3'd7, rv);
        checkOutput("mulLow", 16'(rv), 16'h00);
        checkOutput("mulWbDone", 16'(done), 16'd0);
        checkOutput("mulWbReady", 16'(inReady), 16'd0);
        @(negedge clk);
        readReg(3'd0, rv);
        checkOutput("mulHighWrap", 16'(rv), 16'h02);
        checkOutput("mulDone", 16'(done), 16'd1);
        checkOutput("mulReadyBack", 16'(inReady), 16'd1);
        @(posedge clk); #1;

        // Back-to-back issue with in_valid held
        applyStimulus(4'd0, 3'd2, 3'd1, 1'b1, a1);
        applyStimulus(4'd2, 3'd6, 3'd2, 1'b0, a2);
        checkOutput("backToBackGap", 16'(a2 - a1), 16'd2);
        idleCycles(3);

        // Host write while an instruction is offered
        hostWrEn = 1'b1; hostWrAddr = 3'd3; hostWrData = 8'h55;
        inValid = 1'b1; inInstr = {4'd0, 3'd3, 3'd3, 6'd0};
        @(negedge clk);
        checkOutput("hostBlocksReady", 16'(inReady), 16'd0);
        @(posedge clk); #1;
        hostWrEn = 1'b0; inValid = 1'b0;
        @(negedge clk);
        readReg(3'd3, rv);
        checkOutput("hostWrote", 16'(rv), 16'h55);
        idleCycles(3);

        // Reset during EXEC of an ADD into R4
        applyStimulus(4'd0, 3'd4, 3'd1, 1'b0, a1);
        rst_n = 1'b0;
        idleCycles(2);
        rst_n = 1'b1;
        @(negedge clk);
        readReg(3'd4, rv);
        checkOutput("abortR4", 16'(rv), 16'h00);
        checkOutput("abortDone", 16'(done), 16'd0);
        checkOutput("abortReady", 16'(inReady), 16'd1);
        @(posedge clk); #1;

        // COMPARE 0x09 vs 0x03
        hostWrite(3'd5, 8'h09);
        hostWrite(3'd6, 8'h03);
        applyStimulus(4'd15, 3'd5, 3'd6, 1'b0, a1);
        @(negedge clk);
        @(negedge clk);
        readReg(3'd5, rv);
        checkOutput("cmpR5", 16'(rv), 16'h01);
        checkOutput("cmpSreg", 16'(sreg), 16'h0);
        @(posedge clk); #1;

        // Randomized traffic against the model
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                hostWrite(3'($urandom), 8'($urandom));
            end else begin
                dbgAddr = 3'($urandom);
                applyStimulus(4'($urandom), 3'($urandom), 3'($urandom),
                              1'($urandom_range(0, 1)), a1);
            end
            dbgAddr = 3'($urandom);
            idleCycles($urandom_range(0, 2));
        end
        inValid = 1'b0;
        idleCycles(4);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
